// File: rtl/alu_issue_pkg.sv
// alu_issue shared types: operation codes, ALU op encodings, widths.
// Optional feature macro: ALU_OFL_TRAP_EN (see alu_issue.sv).
package alu_issue_pkg;

  localparam int DW = 16;
  localparam int TW = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_ANDN = 4'd3,
    OP_ROL  = 4'd4,
    OP_SLL  = 4'd5,
    OP_ROR  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SEQ  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLE  = 4'd10,
    OP_SCO  = 4'd11,
    OP_MOV  = 4'd12
  } in_op_e;

  localparam logic [2:0] AOP_ROL = 3'b000;
  localparam logic [2:0] AOP_SLL = 3'b001;
  localparam logic [2:0] AOP_ROR = 3'b010;
  localparam logic [2:0] AOP_SRL = 3'b011;
  localparam logic [2:0] AOP_ADD = 3'b100;
  localparam logic [2:0] AOP_XOR = 3'b110;
  localparam logic [2:0] AOP_AND = 3'b111;

  typedef struct packed {
    logic [2:0] op;
    logic       cin;
    logic       inva;
    logic       invb;
    logic       sign;
    logic       zero_b;
  } dec_t;

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: maps in_op to ALU op and operand controls.
// Combinational; codes 12-15 all decode as MOV.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [3:0] i_op,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_op)
      OP_ADD: begin
        o_dec.op   = AOP_ADD;
        o_dec.sign = 1'b1;
      end
      OP_SUB: begin
        o_dec.op   = AOP_ADD;
        o_dec.inva = 1'b1;
        o_dec.cin  = 1'b1;
        o_dec.sign = 1'b1;
      end
      OP_XOR:  o_dec.op = AOP_XOR;
      OP_ANDN: begin
        o_dec.op   = AOP_AND;
        o_dec.invb = 1'b1;
      end
      OP_ROL: o_dec.op = AOP_ROL;
      OP_SLL: o_dec.op = AOP_SLL;
      OP_ROR: o_dec.op = AOP_ROR;
      OP_SRL: o_dec.op = AOP_SRL;
      // set-conditions all compute Rs - Rt
      OP_SEQ, OP_SLT, OP_SLE: begin
        o_dec.op   = AOP_ADD;
        o_dec.invb = 1'b1;
        o_dec.cin  = 1'b1;
        o_dec.sign = 1'b1;
      end
      OP_SCO: o_dec.op = AOP_ADD;
      default: begin
        o_dec.op     = AOP_XOR;
        o_dec.zero_b = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/writeback wrapper around the 16-bit ALU.
// Define ALU_OFL_TRAP_EN to add the ovf_exc output for ADD/SUB overflow.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [TW-1:0] in_rd,
  input  logic          flush,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  output logic          alu_cin,
  output logic          alu_inva,
  output logic          alu_invb,
  output logic          alu_sign,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_ofl,
  input  logic          alu_ltz,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [TW-1:0] out_rd
`ifdef ALU_OFL_TRAP_EN
  ,
  output logic          ovf_exc
`endif
);

  dec_t          w_dec;
  dec_t          r_dec;
  logic          r_s1_valid;
  logic          r_s2_valid;
  logic [3:0]    r_s1_op;
  logic [TW-1:0] r_s1_rd;
  logic [TW-1:0] r_s2_rd;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [DW-1:0] r_s2_data;
  logic [DW-1:0] w_res;
  logic          w_adv2;
  logic          w_acc;
  logic          w_lt;
  logic          w_zero;
  logic          w_unused;

  assign w_unused = alu_ltz;

  alu_issue_dec u_dec (
    .i_op  (in_op),
    .o_dec (w_dec)
  );

  assign w_adv2   = ~r_s2_valid | out_ready;
  assign in_ready = (~r_s1_valid | w_adv2) & ~flush;
  assign w_acc    = in_valid & in_ready;

  assign w_zero = (alu_out == '0);
  assign w_lt   = alu_out[DW-1] ^ alu_ofl;

  always_comb begin
    w_res = alu_out;
    case (r_s1_op)
      OP_SEQ:  w_res = {{(DW-1){1'b0}}, w_zero};
      OP_SLT:  w_res = {{(DW-1){1'b0}}, w_lt};
      OP_SLE:  w_res = {{(DW-1){1'b0}}, w_lt | w_zero};
      OP_SCO:  w_res = {{(DW-1){1'b0}}, alu_ofl};
      default: w_res = alu_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_rd    <= '0;
      r_s2_rd    <= '0;
      r_s2_data  <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_dec      <= '0;
    end else if (flush) begin
      // data registers keep their values; only occupancy is killed
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_res;
          r_s2_rd   <= r_s1_rd;
        end
      end
      if (in_ready) r_s1_valid <= in_valid;
      if (w_acc) begin
        r_alu_a <= in_a;
        r_alu_b <= w_dec.zero_b ? '0 : in_b;
        r_dec   <= w_dec;
        r_s1_op <= in_op;
        r_s1_rd <= in_rd;
      end
    end
  end

`ifdef ALU_OFL_TRAP_EN
  logic r_s2_ovf;
  logic w_trap;

  assign w_trap = alu_ofl &
    ((r_s1_op == OP_ADD) | (r_s1_op == OP_SUB));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_ovf <= 1'b0;
    end else if (!flush && w_adv2 && r_s1_valid) begin
      r_s2_ovf <= w_trap;
    end
  end

  assign ovf_exc = r_s2_ovf & r_s2_valid;
`endif

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_dec.op;
  assign alu_cin   = r_dec.cin;
  assign alu_inva  = r_dec.inva;
  assign alu_invb  = r_dec.invb;
  assign alu_sign  = r_dec.sign;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_rd    = r_s2_rd;

endmodule
